// File: rtl/iob_ethmac_mem_arbiter.sv
// ---------------------------------------------------------------------------
// iob_ethmac_mem_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter sharing one IOb memory port.
//   Requester 0 is the ethmac DMA master, requester 1 is the CPU/system data
//   port. One transaction is in flight at a time. A watchdog ends any
//   transaction the memory never acknowledges and returns zero read data.
//
// Ports:
//   clk_i, arst_n_i          clock, asynchronous active-low reset
//   r0_valid/addr/wdata/wstrb   DMA request (wstrb == 0 means read)
//   r0_rdata/r0_ready           DMA completion (one-cycle ready pulse)
//   r1_*                        same set for the CPU requester
//   m_valid/addr/wdata/wstrb    shared-port request (registered)
//   m_rdata/m_ready             shared-port response
//   busy_o                      high while a transaction is in flight
//   timeout_o                   one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module iob_ethmac_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    // requester 0 (DMA)
    input  logic                r0_valid,
    input  logic [ADDR_W-1:0]   r0_addr,
    input  logic [DATA_W-1:0]   r0_wdata,
    input  logic [DATA_W/8-1:0] r0_wstrb,
    output logic [DATA_W-1:0]   r0_rdata,
    output logic                r0_ready,
    // requester 1 (CPU)
    input  logic                r1_valid,
    input  logic [ADDR_W-1:0]   r1_addr,
    input  logic [DATA_W-1:0]   r1_wdata,
    input  logic [DATA_W/8-1:0] r1_wstrb,
    output logic [DATA_W-1:0]   r1_rdata,
    output logic                r1_ready,
    // shared memory port
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,
    // status
    output logic                busy_o,
    output logic                timeout_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

    state_t               state;
    logic                 prio;     // requester favoured when both ask
    logic                 gnt;      // requester owning the in-flight transaction
    logic [TIMEOUT_W-1:0] wdog;

    logic pick;       // requester that would be granted this cycle in IDLE
    logic ack;        // memory completes the transaction this cycle
    logic expire;     // watchdog ends the transaction this cycle
    logic done;

    // A lone requester wins outright; a tie goes to the favoured one.
    assign pick   = (r0_valid && r1_valid) ? prio : r1_valid;

    // A real acknowledge in the watchdog cycle takes precedence over expiry.
    assign ack    = (state == BUSY) && m_ready;
    assign expire = (state == BUSY) && !m_ready && (wdog == WDOG_MAX);
    assign done   = ack || expire;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create order-dependent
    // races between this block and any other clocked logic.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state   <= IDLE;
            prio    <= 1'b0;
            gnt     <= 1'b0;
            wdog    <= '0;
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // m_ready seen here is a late acknowledge and is ignored.
                    if (r0_valid || r1_valid) begin
                        gnt     <= pick;
                        m_valid <= 1'b1;
                        m_addr  <= pick ? r1_addr  : r0_addr;
                        m_wdata <= pick ? r1_wdata : r0_wdata;
                        m_wstrb <= pick ? r1_wstrb : r0_wstrb;
                        wdog    <= '0;
                        busy_o  <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        // Hand priority to the other requester so neither
                        // can starve the other with back-to-back requests.
                        m_valid <= 1'b0;
                        prio    <= ~gnt;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is routed combinationally to the owning requester only.
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        r0_rdata  = '0;
        r1_rdata  = '0;
        timeout_o = expire;
        if (done) begin
            if (gnt) begin
                r1_ready = 1'b1;
                r1_rdata = ack ? m_rdata : '0;
            end else begin
                r0_ready = 1'b1;
                r0_rdata = ack ? m_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_iob_ethmac_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iob_ethmac_mem_arbiter
//
// Drives both requesters and a behavioural memory. The reference model is
// transaction level: the next winner follows from which requesters are
// waiting and who was served last, and each transaction ends either at the
// memory's chosen acknowledge cycle or at the watchdog limit.
// Inputs change and outputs are sampled around the falling clock edge.
// ---------------------------------------------------------------------------
module tb_iob_ethmac_mem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int TW     = 4;
    localparam int WD_MAX = (1 << TW) - 1;

    logic clk_i = 1'b0;
    logic arst_n_i;

    logic [1:0]         r_valid;
    logic [1:0][AW-1:0] r_addr;
    logic [1:0][DW-1:0] r_wdata;
    logic [1:0][SW-1:0] r_wstrb;

    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          r0_ready, r1_ready;
    logic [1:0]    r_ready;

    logic          m_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic [DW-1:0] m_rdata;
    logic          m_ready;
    logic          busy_o;
    logic          timeout_o;

    int errors = 0;
    int checks = 0;
    int ref_prio = 0;   // requester the model expects to win a tie

    always #5 clk_i = ~clk_i;

    assign r_ready = {r1_ready, r0_ready};

    iob_ethmac_mem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TIMEOUT_W(TW)
    ) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .r0_valid (r_valid[0]),
        .r0_addr  (r_addr[0]),
        .r0_wdata (r_wdata[0]),
        .r0_wstrb (r_wstrb[0]),
        .r0_rdata (r0_rdata),
        .r0_ready (r0_ready),
        .r1_valid (r_valid[1]),
        .r1_addr  (r_addr[1]),
        .r1_wdata (r_wdata[1]),
        .r1_wstrb (r_wstrb[1]),
        .r1_rdata (r1_rdata),
        .r1_ready (r1_ready),
        .m_valid  (m_valid),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .busy_o   (busy_o),
        .timeout_o(timeout_o)
    );

    // Fresh random payload; address MSB tags the requester so a wrong grant
    // always shows up as an address difference.
    task automatic new_payload(input int i);
        r_addr[i]  = {i[0], 31'($urandom)};
        r_wdata[i] = $urandom;
        r_wstrb[i] = 4'($urandom);
    endtask

    // Runs one arbitrated transaction starting from IDLE at a falling edge.
    // The memory acknowledges in BUSY cycle 'lat' (0 = first BUSY cycle);
    // a latency beyond the watchdog limit means it never answers.
    task automatic mem_serve(input int lat, input logic [DW-1:0] data,
                             input bit keep, output int served);
        int            id;
        bit            fin;
        logic [1:0]    exp_rdy;
        logic [DW-1:0] exp_rd0, exp_rd1;
        logic          exp_to;
        id = (r_valid[0] && r_valid[1]) ? ref_prio : (r_valid[1] ? 1 : 0);
        served = id;
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (m_valid !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL grant_latency: m_valid=%b busy=%b, required 1 1", m_valid, busy_o);
        end
        checks++;
        if (m_addr !== r_addr[id] || m_wdata !== r_wdata[id] || m_wstrb !== r_wstrb[id]) begin
            errors++;
            $display("FAIL grant_payload: addr=%h wdata=%h wstrb=%h, required %h %h %h (r%0d)",
                     m_addr, m_wdata, m_wstrb, r_addr[id], r_wdata[id], r_wstrb[id], id);
        end
        fin = 0;
        for (int c = 0; c <= WD_MAX && !fin; c++) begin
            if (c > 0) begin
                @(negedge clk_i);
                checks++;
                if (m_valid !== 1'b1 || m_addr !== r_addr[id]) begin
                    errors++;
                    $display("FAIL busy_hold: cycle %0d m_valid=%b addr=%h, required 1 %h",
                             c, m_valid, m_addr, r_addr[id]);
                end
            end
            if (c == lat) begin
                m_ready = 1'b1;
                m_rdata = data;
            end else begin
                m_ready = 1'b0;
                m_rdata = $urandom;
            end
            #1;
            exp_rdy = 2'b00;
            exp_rd0 = '0;
            exp_rd1 = '0;
            exp_to  = 1'b0;
            if (c == lat || c == WD_MAX) begin
                fin = 1;
                exp_rdy[id] = 1'b1;
                exp_to = (c != lat);
                if (id == 0) exp_rd0 = (c == lat) ? data : '0;
                else         exp_rd1 = (c == lat) ? data : '0;
            end
            checks++;
            if (r_ready !== exp_rdy || r0_rdata !== exp_rd0 || r1_rdata !== exp_rd1
                || timeout_o !== exp_to) begin
                errors++;
                $display("FAIL response: cycle %0d ready=%b rd0=%h rd1=%h to=%b, required %b %h %h %b",
                         c, r_ready, r0_rdata, r1_rdata, timeout_o,
                         exp_rdy, exp_rd0, exp_rd1, exp_to);
            end
            @(posedge clk_i);
        end
        @(negedge clk_i);
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL release: m_valid=%b busy=%b to=%b, required 0 0 0",
                     m_valid, busy_o, timeout_o);
        end
        ref_prio = 1 - id;
        if (keep) new_payload(id);
        else r_valid[id] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        arst_n_i = 1'b0;
        r_valid  = 2'b00;
        m_ready  = 1'b0;
        ref_prio = 0;
        repeat (2) @(negedge clk_i);
        arst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        arst_n_i = 1'b0;
        r_valid  = 2'b00;
        r_addr   = '0;
        r_wdata  = '0;
        r_wstrb  = '0;
        m_ready  = 1'b0;
        m_rdata  = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk_i);
        checks++;
        if (m_valid !== 1'b0 || m_addr !== '0 || m_wdata !== '0 || m_wstrb !== '0) begin
            errors++;
            $display("FAIL reset_mport: valid=%b addr=%h wdata=%h wstrb=%h, required all 0",
                     m_valid, m_addr, m_wdata, m_wstrb);
        end
        checks++;
        if (busy_o !== 1'b0 || timeout_o !== 1'b0 || r_ready !== 2'b00
            || r0_rdata !== '0 || r1_rdata !== '0) begin
            errors++;
            $display("FAIL reset_status: busy=%b to=%b ready=%b rd0=%h rd1=%h, required all 0",
                     busy_o, timeout_o, r_ready, r0_rdata, r1_rdata);
        end
        arst_n_i = 1'b1;
        ref_prio = 0;
    endtask

    task automatic test_single_read();
        int s;
        r_valid[0] = 1'b1;
        r_addr[0]  = 32'h0000_0100;
        r_wdata[0] = 32'h0;
        r_wstrb[0] = 4'b0000;
        mem_serve(3, 32'hDEAD_BEEF, 0, s);
        checks++;
        if (s != 0) begin
            errors++;
            $display("FAIL single_read_id: served r%0d, required r0", s);
        end
    endtask

    task automatic test_round_robin();
        int s;
        int exp_seq[5] = '{0, 1, 0, 1, 0};
        do_reset();
        new_payload(0);
        new_payload(1);
        r_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            mem_serve(int'($urandom_range(0, 3)), $urandom, 1, s);
            checks++;
            if (s != exp_seq[k]) begin
                errors++;
                $display("FAIL round_robin: grant %0d went to r%0d, required r%0d", k, s, exp_seq[k]);
            end
        end
        r_valid = 2'b00;
    endtask

    task automatic test_write();
        int s;
        r_valid[1] = 1'b1;
        r_addr[1]  = 32'h0000_0040;
        r_wdata[1] = 32'hCAFE_0000;
        r_wstrb[1] = 4'b1100;
        mem_serve(2, $urandom, 0, s);
        checks++;
        if (s != 1) begin
            errors++;
            $display("FAIL write_id: served r%0d, required r1", s);
        end
    endtask

    task automatic test_timeout();
        int s;
        do_reset();
        r_valid[0] = 1'b1;
        new_payload(0);
        mem_serve(1000, $urandom, 0, s);
        // Both waiting now: the timed-out requester loses the tie.
        new_payload(0);
        new_payload(1);
        r_valid = 2'b11;
        mem_serve(1, $urandom, 0, s);
        checks++;
        if (s != 1) begin
            errors++;
            $display("FAIL timeout_next_grant: served r%0d, required r1", s);
        end
        r_valid = 2'b00;
    endtask

    task automatic test_edge_ack();
        int s;
        r_valid[0] = 1'b1;
        new_payload(0);
        mem_serve(WD_MAX, 32'h1234_5678, 0, s);
        // Late acknowledge while idle must not reach either requester.
        @(negedge clk_i);
        m_ready = 1'b1;
        m_rdata = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (r_ready !== 2'b00 || r0_rdata !== '0 || r1_rdata !== '0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: ready=%b rd0=%h rd1=%h to=%b, required 00 0 0 0",
                     r_ready, r0_rdata, r1_rdata, timeout_o);
        end
        @(negedge clk_i);
        m_ready = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_state: busy=%b m_valid=%b, required 0 0", busy_o, m_valid);
        end
    endtask

    task automatic test_async_reset();
        int s;
        // Serve r0 once so the tie favours r1 before the reset.
        r_valid[0] = 1'b1;
        new_payload(0);
        mem_serve(0, $urandom, 1, s);
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: busy=%b, required 1", busy_o);
        end
        #2;
        arst_n_i = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy_o !== 1'b0 || r_ready !== 2'b00 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL areset_async: m_valid=%b busy=%b ready=%b to=%b, required 0 0 00 0",
                     m_valid, busy_o, r_ready, timeout_o);
        end
        ref_prio = 0;
        @(negedge clk_i);
        arst_n_i = 1'b1;
        new_payload(1);
        r_valid = 2'b11;
        mem_serve(2, $urandom, 0, s);
        checks++;
        if (s != 0) begin
            errors++;
            $display("FAIL areset_prio: served r%0d, required r0", s);
        end
        r_valid = 2'b00;
    endtask

    task automatic test_random();
        int s;
        int lat;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!r_valid[i] && $urandom_range(0, 1) == 1) begin
                    r_valid[i] = 1'b1;
                    new_payload(i);
                end
            end
            if (r_valid == 2'b00) begin
                r_valid[n % 2] = 1'b1;
                new_payload(n % 2);
            end
            lat = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 5));
            mem_serve(lat, $urandom, bit'($urandom_range(0, 1)), s);
        end
        r_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_timeout();
        test_edge_ack();
        test_async_reset();
        test_random();
        repeat (2) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
